shared_resource_arbiter: RTL and testbench
==========================================

Name: shared_resource_arbiter

Overview:
- Sequences one multi-cycle shared resource between pipeline 1 and pipeline 2 inside pipeline_wrapped.
- Accepts one request at a time with round-robin fairness and stalls the losing pipeline.
- Issues the operand to the resource with a start/done handshake and returns the result to the owning pipeline, honouring downstream stall.
- Discards in-flight work for a flushed pipeline and recovers from a hung resource with a watchdog.

Parameters:
DATA_W, 32, width of request operands and resource results
TIMEOUT_CYC, 255, maximum cycles in WAIT before the transaction is abandoned

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_valid_1  input  1  pipeline 1 request valid
req_data_1  input  DATA_W  pipeline 1 operand
flush_1  input  1  pipeline 1 flush
out_stall_1  output  1  stall back to pipeline 1
rsp_valid_1  output  1  result valid to pipeline 1
rsp_data_1  output  DATA_W  result to pipeline 1
in_stall_1  input  1  downstream stall on pipeline 1 result
req_valid_2, req_data_2, flush_2, out_stall_2, rsp_valid_2, rsp_data_2, in_stall_2  same widths and directions as above, for pipeline 2
res_start  output  1  one-cycle start pulse to the resource
res_operand  output  DATA_W  operand to the resource, held stable through WAIT
res_done  input  1  resource completion pulse
res_result  input  DATA_W  resource result, valid with res_done
owner  output  1  0 = pipeline 1, 1 = pipeline 2; valid when busy
busy  output  1  state is not IDLE
err_timeout  output  1  sticky watchdog flag; cleared only by reset

Behaviour:
Reset (reset low, asynchronous):
- State is IDLE and rr_ptr = 0.
- All outputs are 0, including the data outputs, owner and err_timeout.

Candidates and grant:
- A pipeline is a candidate when its req_valid is high and its flush is low.
- IDLE, one candidate: that candidate is granted.
- IDLE, two candidates: grant goes to the pipeline selected by rr_ptr (0 selects pipeline 1).
- On grant: latch the operand into res_operand, set owner, go to ISSUE.

Stall (combinational):
- out_stall_x = req_valid_x && !flush_x && !(state==IDLE && grant_x).
- The granted pipeline sees stall low during its grant cycle, and that cycle's edge consumes its request.
- A stalled pipeline holds req_valid and req_data unchanged.

States:
- ISSUE: res_start = 1 for exactly one cycle; go to WAIT. res_done is ignored in ISSUE.
- WAIT: the watchdog counter increments each cycle.
  - On res_done: capture res_result; go to RESP, or to IDLE if a flush is pending.
  - If the counter reaches TIMEOUT_CYC with no res_done: set err_timeout, drop the transaction, go to IDLE.
- RESP: rsp_valid_owner = 1 and rsp_data_owner = captured result, held while in_stall_owner = 1.
  - When in_stall_owner = 0, the response is consumed at that edge; go to IDLE.
  - Non-owner rsp_valid stays 0.

Flush:
- flush_owner asserted in ISSUE or WAIT sets flush_pending. The resource still completes, but its result is discarded.
- flush_owner in RESP drops rsp_valid the next cycle; go to IDLE.
- flush of the non-owner has no effect on the transaction; it only masks that pipeline's request.

Fairness:
- On every exit to IDLE (completed, flushed or timed out): rr_ptr = ~owner.
- Consequence: under continuous contention, grants strictly alternate.

Latency:
- Grant at edge T; res_start during cycle T+1; earliest res_done sampled at T+2; rsp_valid at T+3.
- Next grant is possible in the cycle after the response is consumed (one IDLE cycle between transactions).

Simultaneous events:
- A res_done coinciding with the timeout cycle counts as done; err_timeout is not set.
- A flush coinciding with res_done discards the result.

Decomposition:
- arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP) and OWNER_P1/OWNER_P2 constants.
- Sub-module rr_picker: combinational two-way round-robin grant from the candidates and rr_ptr.
- The FSM, watchdog counter ($clog2(TIMEOUT_CYC+1) bits) and datapath registers stay in the top module.

Test Plan:
- Single request, no contention: req_valid_1 = 1 with 0x0000_00AA, resource done after 3 cycles returning 0x0000_0155 -> res_start one cycle after grant; rsp_valid_1 with 0x155 one cycle after res_done; owner = 0; rsp_valid_2 stays 0.
- Contention: both requesters hold valid continuously for 4 transactions -> grant order 1, 2, 1, 2; out_stall is high on the waiting pipeline every cycle until its grant.
- Flush in WAIT: grant pipeline 2, pulse flush_2 before res_done -> no rsp_valid_2; return to IDLE; rr_ptr = 0; next grant serves a pending pipeline 1 request.
- Downstream stall: in_stall_1 high for 5 cycles in RESP -> rsp_valid_1 and rsp_data_1 held stable for 5 cycles; consumed on the first cycle in_stall_1 is low.
- Hung resource with TIMEOUT_CYC = 8: res_done never arrives -> err_timeout rises after 8 WAIT cycles and stays high; no response; arbiter serves the next request normally.
- Reset mid-operation: assert reset low during WAIT -> all outputs 0 asynchronously; after release, IDLE with rr_ptr = 0 and err_timeout = 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the two-pipeline shared-resource arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OWNER_P1 = 1'b0;
  localparam logic OWNER_P2 = 1'b1;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin picker: a lone candidate always wins, and a tie is
// broken by rr_ptr (0 favours pipeline 1).
module rr_picker (
  input  logic cand_1,
  input  logic cand_2,
  input  logic rr_ptr,
  output logic grant_1,
  output logic grant_2
);

  // Grants are mutually exclusive by construction.
  always_comb begin
    grant_1 = cand_1 && (!cand_2 || !rr_ptr);
    grant_2 = cand_2 && (!cand_1 || rr_ptr);
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Shares one multi-cycle resource between two pipelines: round-robin grant,
// start/done handshake, stall-aware response return, flush and watchdog.
//
// state | meaning
// IDLE  | no transaction; arbitrate between candidates
// ISSUE | one-cycle res_start pulse with the latched operand
// WAIT  | waiting for res_done; watchdog running
// RESP  | result presented to the owner until consumed or flushed
module shared_resource_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_1,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic              flush_1,
  output logic              out_stall_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_1,
  input  logic              in_stall_1,
  input  logic              req_valid_2,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              flush_2,
  output logic              out_stall_2,
  output logic              rsp_valid_2,
  output logic [DATA_W-1:0] rsp_data_2,
  input  logic              in_stall_2,
  output logic              res_start,
  output logic [DATA_W-1:0] res_operand,
  input  logic              res_done,
  input  logic [DATA_W-1:0] res_result,
  output logic              owner,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // WAIT cycle number k holds count k-1, so the last allowed cycle is TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic                owner_q, owner_d;
  logic                flush_pend_q, flush_pend_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   operand_q, operand_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic cand_1, cand_2, grant_1, grant_2;
  logic is_idle, flush_own, in_stall_own;

  assign cand_1       = req_valid_1 && !flush_1;
  assign cand_2       = req_valid_2 && !flush_2;
  assign is_idle      = (state_q == IDLE);
  assign flush_own    = (owner_q == OWNER_P2) ? flush_2 : flush_1;
  assign in_stall_own = (owner_q == OWNER_P2) ? in_stall_2 : in_stall_1;

  rr_picker u_rr_picker (
    .cand_1  (cand_1),
    .cand_2  (cand_2),
    .rr_ptr  (rr_ptr_q),
    .grant_1 (grant_1),
    .grant_2 (grant_2)
  );

  assign out_stall_1 = cand_1 && !(is_idle && grant_1);
  assign out_stall_2 = cand_2 && !(is_idle && grant_2);
  assign res_start   = (state_q == ISSUE);
  assign res_operand = operand_q;
  assign rsp_valid_1 = (state_q == RESP) && (owner_q == OWNER_P1);
  assign rsp_valid_2 = (state_q == RESP) && (owner_q == OWNER_P2);
  // Data is gated so non-owner and idle outputs read as zero.
  assign rsp_data_1  = rsp_valid_1 ? result_q : '0;
  assign rsp_data_2  = rsp_valid_2 ? result_q : '0;
  assign owner       = owner_q;
  assign busy        = !is_idle;
  assign err_timeout = err_q;

  // Next-state logic for the transaction FSM, watchdog and datapath.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    flush_pend_d = flush_pend_q;
    err_d        = err_q;
    operand_d    = operand_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_1 || grant_2) begin
          owner_d      = grant_2 ? OWNER_P2 : OWNER_P1;
          operand_d    = grant_2 ? req_data_2 : req_data_1;
          flush_pend_d = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (flush_own) flush_pend_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as completion.
        if (res_done) begin
          if (flush_pend_q || flush_own) begin
            rr_ptr_d = ~owner_q;
            state_d  = IDLE;
          end else begin
            result_d = res_result;
            state_d  = RESP;
          end
        end else begin
          if (flush_own) flush_pend_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            err_d    = 1'b1;
            rr_ptr_d = ~owner_q;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESP: begin
        if (flush_own || !in_stall_own) begin
          rr_ptr_d = ~owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      owner_q      <= OWNER_P1;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
      operand_q    <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
      operand_q    <= operand_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: transaction-level driver with a
// round-robin reference model, response scoreboard and independent monitor.
module tb_shared_resource_arbiter;

  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_1, flush_1, in_stall_1, out_stall_1, rsp_valid_1;
  logic          req_valid_2, flush_2, in_stall_2, out_stall_2, rsp_valid_2;
  logic [DW-1:0] req_data_1, req_data_2, rsp_data_1, rsp_data_2;
  logic          res_start, res_done, owner, busy, err_timeout;
  logic [DW-1:0] res_operand, res_result;

  always #5 clk = ~clk;

  shared_resource_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_1(req_valid_1), .req_data_1(req_data_1), .flush_1(flush_1),
    .out_stall_1(out_stall_1), .rsp_valid_1(rsp_valid_1), .rsp_data_1(rsp_data_1),
    .in_stall_1(in_stall_1),
    .req_valid_2(req_valid_2), .req_data_2(req_data_2), .flush_2(flush_2),
    .out_stall_2(out_stall_2), .rsp_valid_2(rsp_valid_2), .rsp_data_2(rsp_data_2),
    .in_stall_2(in_stall_2),
    .res_start(res_start), .res_operand(res_operand), .res_done(res_done),
    .res_result(res_result), .owner(owner), .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct {
    bit            pipe;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   model_ptr = 1'b0;
  bit   err_exp = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // The bench's resource computes 2x+1.
  function automatic logic [DW-1:0] res_fn(input logic [DW-1:0] x);
    return (x << 1) + 32'd1;
  endfunction

  task automatic set_flush(input bit pipe, input bit val);
    if (pipe) flush_2 = val; else flush_1 = val;
  endtask

  task automatic set_istall(input bit pipe, input bit val);
    if (pipe) in_stall_2 = val; else in_stall_1 = val;
  endtask

  task automatic chk_stall(input bit idle, input bit win);
    chk1("out_stall_1", out_stall_1, req_valid_1 && !flush_1 && !(idle && !win));
    chk1("out_stall_2", out_stall_2, req_valid_2 && !flush_2 && !(idle && win));
  endtask

  // fmode: 0 none, 1 flush owner at WAIT cycle fcyc (0 = ISSUE),
  //        2 flush non-owner at WAIT cycle fcyc, 3 flush owner at RESP cycle fcyc.
  task automatic run_txn(input bit r1, input bit r2, input logic [DW-1:0] d1,
                         input logic [DW-1:0] d2, input int dly, input int fmode,
                         input int fcyc, input int nstall, input bit rereq);
    bit            own, flushed, done_ok, fl_now;
    logic [DW-1:0] op;
    if (r1 && !req_valid_1) begin req_valid_1 = 1'b1; req_data_1 = d1; end
    if (r2 && !req_valid_2) begin req_valid_2 = 1'b1; req_data_2 = d2; end
    if (!req_valid_1 && !req_valid_2) begin req_valid_1 = 1'b1; req_data_1 = d1; end
    own = (req_valid_1 && req_valid_2) ? model_ptr : req_valid_2;
    op  = own ? req_data_2 : req_data_1;
    set_istall(!own, 1'($urandom_range(0, 1)));
    // grant cycle
    @(negedge clk);
    chk1("busy_idle", busy, 1'b0);
    chk1("err_timeout", err_timeout, err_exp);
    chk_stall(1'b1, own);
    @(posedge clk); #1;
    if (own) begin
      req_valid_2 = rereq;
      if (rereq) req_data_2 = $urandom;
    end else begin
      req_valid_1 = rereq;
      if (rereq) req_data_1 = $urandom;
    end
    // ISSUE, with an occasional stray done that must be ignored
    flushed = (fmode == 1 && fcyc == 0);
    if (flushed) set_flush(own, 1'b1);
    res_done   = ($urandom_range(0, 3) == 0);
    res_result = $urandom;
    @(negedge clk);
    chk1("res_start_issue", res_start, 1'b1);
    chk32("res_operand", res_operand, op);
    chk1("owner", owner, own);
    chk1("busy_issue", busy, 1'b1);
    chk_stall(1'b0, own);
    @(posedge clk); #1;
    flush_1 = 1'b0; flush_2 = 1'b0; res_done = 1'b0;
    // WAIT
    done_ok = 1'b0;
    for (int k = 1; k <= TMO && !done_ok; k++) begin
      if (fmode == 1 && fcyc == k) begin set_flush(own, 1'b1); flushed = 1'b1; end
      if (fmode == 2 && fcyc == k) set_flush(!own, 1'b1);
      if (k == dly) begin res_done = 1'b1; res_result = res_fn(op); done_ok = 1'b1; end
      @(negedge clk);
      chk1("res_start_wait", res_start, 1'b0);
      chk32("operand_held", res_operand, op);
      chk1("busy_wait", busy, 1'b1);
      chk1("no_rsp_wait", rsp_valid_1 || rsp_valid_2, 1'b0);
      chk_stall(1'b0, own);
      if (done_ok && !flushed) sb.push_back('{own, res_result});
      @(posedge clk); #1;
      flush_1 = 1'b0; flush_2 = 1'b0; res_done = 1'b0;
    end
    if (!done_ok) err_exp = 1'b1;
    // RESP
    if (done_ok && !flushed) begin
      for (int s = 0; s <= nstall; s++) begin
        set_istall(own, s < nstall);
        fl_now = (fmode == 3 && fcyc == s);
        if (fl_now) set_flush(own, 1'b1);
        @(negedge clk);
        chk1("rsp_valid_owner", own ? rsp_valid_2 : rsp_valid_1, 1'b1);
        chk1("rsp_valid_other", own ? rsp_valid_1 : rsp_valid_2, 1'b0);
        chk_stall(1'b0, own);
        @(posedge clk); #1;
        flush_1 = 1'b0; flush_2 = 1'b0;
        if (fl_now) begin
          if (s < nstall) void'(sb.pop_front());
          break;
        end
      end
    end
    in_stall_1 = 1'b0; in_stall_2 = 1'b0;
    model_ptr = !own;
  endtask

  task automatic drain();
    while (req_valid_1 || req_valid_2)
      run_txn(1'b0, 1'b0, 32'h0, 32'h0, 2, 0, 0, 0, 1'b0);
  endtask

  // Monitor: every presented response must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && (rsp_valid_1 || rsp_valid_2)) begin
      chk1("rsp_onehot", rsp_valid_1 && rsp_valid_2, 1'b0);
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL rsp_spurious: got rsp_valid %b%b, want none (t=%0t)",
                 rsp_valid_2, rsp_valid_1, $time);
      end else begin
        chk1("rsp_pipe", rsp_valid_2, sb[0].pipe);
        chk32("rsp_data", rsp_valid_2 ? rsp_data_2 : rsp_data_1, sb[0].data);
        if (!(rsp_valid_2 ? in_stall_2 : in_stall_1)) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit r1, r2, rr;
    int dly, fm, fc, ns;
    reset = 1'b0;
    req_valid_1 = 0; req_valid_2 = 0; flush_1 = 0; flush_2 = 0;
    in_stall_1 = 0; in_stall_2 = 0; res_done = 0;
    req_data_1 = '0; req_data_2 = '0; res_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk1("rst_err", err_timeout, 1'b0);
    chk1("rst_start", res_start, 1'b0);
    chk32("rst_operand", res_operand, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // continuous contention: expect 1,2,1,2
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, $urandom, $urandom, 2, 0, 0, 0, 1'b1);
    drain();
    // single request, done after 3 cycles
    run_txn(1'b1, 1'b0, 32'h0000_00AA, 32'h0, 3, 0, 0, 0, 1'b0);
    // pipeline 2 flushed in WAIT, pending pipeline 1 served next
    run_txn(1'b1, 1'b1, $urandom, $urandom, 5, 1, 2, 0, 1'b0);
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 2, 0, 0, 0, 1'b0);
    // downstream stall for 5 cycles
    run_txn(1'b1, 1'b0, $urandom, 32'h0, 2, 0, 0, 5, 1'b0);
    // hung resource, then normal service
    run_txn(1'b0, 1'b1, 32'h0, $urandom, 100, 0, 0, 0, 1'b0);
    run_txn(1'b1, 1'b0, $urandom, 32'h0, 1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      r1  = 1'($urandom_range(0, 1));
      r2  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      dly = $urandom_range(1, 10);
      ns  = $urandom_range(0, 4);
      fm  = $urandom_range(0, 5);
      if (fm > 3) fm = 0;
      case (fm)
        1:       fc = $urandom_range(0, (dly > TMO) ? TMO : dly);
        2:       fc = $urandom_range(1, TMO);
        3:       fc = $urandom_range(0, ns);
        default: fc = 0;
      endcase
      run_txn(r1, r2, $urandom, $urandom, dly, fm, fc, ns, rr);
    end

    // reset during WAIT with rr_ptr=1, err_timeout set, owner=pipeline 2
    drain();
    run_txn(1'b1, 1'b0, 32'h1234, 32'h0, 1, 0, 0, 0, 1'b0);
    req_valid_2 = 1'b1; req_data_2 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk1("err_sticky", err_timeout, err_exp);
    @(posedge clk); #1;
    req_valid_2 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_owner", owner, 1'b0);
    chk1("arst_err", err_timeout, 1'b0);
    chk32("arst_operand", res_operand, '0);
    chk1("arst_rsp", rsp_valid_1 || rsp_valid_2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; model_ptr = 1'b0; err_exp = 1'b0; sb.delete();
    mon_en = 1'b1;
    run_txn(1'b1, 1'b1, $urandom, $urandom, 3, 0, 0, 1, 1'b0);
    drain();
    @(negedge clk);
    chk32("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
